systolic_feeder: RTL



---
 rtl/systolic_feeder_pkg.sv | 36 +++
 rtl/systolic_feeder_if.sv | 28 ++
 rtl/systolic_feeder_skew_line.sv | 39 +++
 rtl/systolic_feeder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared types and constants for the systolic array edge feeder.
// Column clamping and column-mask helpers live here so the FSM stays compact.
package sys_feeder_pkg;

    localparam int ARRAY_W      = 4;
    localparam int DATA_W       = 16;
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        SWITCH = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4
    } feeder_state_e;

    // 0 and anything above the array width both mean "all columns"
    function automatic logic [2:0] clamp_cols(input logic [2:0] raw);
        logic [2:0] cols;
        if ((raw == 3'd0) || (raw > 3'd4)) begin
            cols = 3'd4;
        end else begin
            cols = raw;
        end
        return cols;
    endfunction

    function automatic logic [ARRAY_W-1:0] col_mask(input logic [2:0] cols);
        logic [ARRAY_W-1:0] mask;
        for (int c = 0; c < ARRAY_W; c++) begin
            mask[c] = (c < int'(cols));
        end
        return mask;
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Unified-buffer read path to feeder handshakes: tile command, weight rows,
// activation vectors and the tile completion pulse.
interface systolic_feeder_if;
    import sys_feeder_pkg::*;

    logic                      tile_valid;
    logic                      tile_ready;
    logic [2:0]                tile_cols;
    logic                      w_valid;
    logic                      w_ready;
    logic [ARRAY_W*DATA_W-1:0] w_row;
    logic                      act_valid;
    logic                      act_ready;
    logic [ARRAY_W*DATA_W-1:0] act_vec;
    logic                      act_last;
    logic                      tile_done;

    modport master (
        output tile_valid, tile_cols, w_valid, w_row, act_valid, act_vec, act_last,
        input  tile_ready, w_ready, act_ready, tile_done
    );

    modport slave (
        input  tile_valid, tile_cols, w_valid, w_row, act_valid, act_vec, act_last,
        output tile_ready, w_ready, act_ready, tile_done
    );

endinterface

// File: rtl/systolic_feeder_skew_line.sv
// Fixed-depth shift register used to diagonally skew one array row.
// Synchronous active-high reset clears every stage.
module skew_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] stage_q [DEPTH];
    logic [DATA_W-1:0] stage_d [DEPTH];

    // next value of every stage: input enters stage 0, others move down
    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // stage registers with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Feeds a 4x4 weight-stationary systolic array: loads one weight tile,
// switches it active, then streams diagonally skewed activations.
module systolic_feeder
    import sys_feeder_pkg::*;
#(
    parameter int SYSTOLIC_ARRAY_WIDTH = ARRAY_W,
    parameter int DATA_WIDTH           = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    systolic_feeder_if.slave      bus,
    output logic [DATA_WIDTH-1:0] fd_weight_out_1,
    output logic [DATA_WIDTH-1:0] fd_weight_out_2,
    output logic [DATA_WIDTH-1:0] fd_weight_out_3,
    output logic [DATA_WIDTH-1:0] fd_weight_out_4,
    output logic                  fd_accept_w_out_1,
    output logic                  fd_accept_w_out_2,
    output logic                  fd_accept_w_out_3,
    output logic                  fd_accept_w_out_4,
    output logic                  fd_switch_out,
    output logic [DATA_WIDTH-1:0] fd_col_size_out,
    output logic                  fd_col_size_valid_out,
    output logic [DATA_WIDTH-1:0] fd_data_out_1,
    output logic [DATA_WIDTH-1:0] fd_data_out_2,
    output logic [DATA_WIDTH-1:0] fd_data_out_3,
    output logic [DATA_WIDTH-1:0] fd_data_out_4,
    output logic                  fd_start_out
);

    feeder_state_e                        state_q, state_d;
    logic [1:0]                           beat_cnt_q, beat_cnt_d;
    logic [2:0]                           cols_q, cols_d;
    logic [DATA_WIDTH-1:0]                col_size_q, col_size_d;
    logic                                 col_size_valid_q, col_size_valid_d;
    logic [ARRAY_W-1:0][DATA_WIDTH-1:0]   weight_q, weight_d;
    logic [ARRAY_W-1:0]                   accept_q, accept_d;
    logic                                 switch_q, switch_d;
    logic                                 done_q, done_d;

    logic                                 w_beat_s;
    logic                                 act_beat_s;
    logic [ARRAY_W-1:0]                   mask_s;
    logic [ARRAY_W-1:0][DATA_WIDTH-1:0]   row_in_s;
    logic [DATA_WIDTH:0]                  row1_out_s;

    assign w_beat_s   = bus.w_valid   && (state_q == LOAD_W);
    assign act_beat_s = bus.act_valid && (state_q == STREAM);
    assign mask_s     = col_mask(cols_q);

    // skew-line inputs: bubble cycles inject zeros
    always_comb begin
        for (int r = 0; r < ARRAY_W; r++) begin
            if (act_beat_s) begin
                row_in_s[r] = bus.act_vec[DATA_WIDTH*r +: DATA_WIDTH];
            end else begin
                row_in_s[r] = '0;
            end
        end
    end

    // FSM next state and next values of every output register
    always_comb begin
        state_d          = state_q;
        beat_cnt_d       = beat_cnt_q;
        cols_d           = cols_q;
        col_size_d       = col_size_q;
        col_size_valid_d = 1'b0;
        weight_d         = '0;
        accept_d         = '0;
        switch_d         = 1'b0;
        done_d           = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.tile_valid) begin
                    cols_d           = clamp_cols(bus.tile_cols);
                    col_size_d       = {{(DATA_WIDTH-3){1'b0}}, clamp_cols(bus.tile_cols)};
                    col_size_valid_d = 1'b1;
                    beat_cnt_d       = 2'd0;
                    state_d          = LOAD_W;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_W: begin
                if (w_beat_s) begin
                    for (int c = 0; c < SYSTOLIC_ARRAY_WIDTH; c++) begin
                        if (mask_s[c]) begin
                            weight_d[c] = bus.w_row[DATA_WIDTH*c +: DATA_WIDTH];
                        end else begin
                            weight_d[c] = '0;
                        end
                    end
                    accept_d   = mask_s;
                    beat_cnt_d = beat_cnt_q + 2'd1;
                    if (beat_cnt_q == 2'd3) begin
                        state_d = SWITCH;
                    end else begin
                        state_d = LOAD_W;
                    end
                end else begin
                    state_d = LOAD_W;
                end
            end
            // two cycles: the first lets the last shift strobe land, the
            // second shows the registered switch pulse with ready still low
            SWITCH: begin
                if (beat_cnt_q == 2'd0) begin
                    switch_d   = 1'b1;
                    beat_cnt_d = 2'd1;
                end else begin
                    beat_cnt_d = 2'd0;
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                if (act_beat_s && bus.act_last) begin
                    beat_cnt_d = 2'd0;
                    state_d    = DRAIN;
                end else begin
                    state_d = STREAM;
                end
            end
            DRAIN: begin
                if (beat_cnt_q == 2'(DRAIN_CYCLES)) begin
                    beat_cnt_d = 2'd0;
                    state_d    = IDLE;
                end else begin
                    beat_cnt_d = beat_cnt_q + 2'd1;
                    if (beat_cnt_q == 2'(DRAIN_CYCLES - 1)) begin
                        done_d = 1'b1;
                    end else begin
                        done_d = 1'b0;
                    end
                end
            end
            default: begin
                beat_cnt_d = 2'd0;
                state_d    = IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            beat_cnt_q       <= 2'd0;
            cols_q           <= 3'd0;
            col_size_q       <= '0;
            col_size_valid_q <= 1'b0;
            weight_q         <= '0;
            accept_q         <= '0;
            switch_q         <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            beat_cnt_q       <= beat_cnt_d;
            cols_q           <= cols_d;
            col_size_q       <= col_size_d;
            col_size_valid_q <= col_size_valid_d;
            weight_q         <= weight_d;
            accept_q         <= accept_d;
            switch_q         <= switch_d;
            done_q           <= done_d;
        end
    end

    // row 1 carries the start bit alongside its data
    skew_line #(.DEPTH(1), .DATA_W(DATA_WIDTH + 1)) u_row1 (
        .clk  (clk),
        .rst  (rst),
        .din  ({act_beat_s, row_in_s[0]}),
        .dout (row1_out_s)
    );

    skew_line #(.DEPTH(2), .DATA_W(DATA_WIDTH)) u_row2 (
        .clk  (clk),
        .rst  (rst),
        .din  (row_in_s[1]),
        .dout (fd_data_out_2)
    );

    skew_line #(.DEPTH(3), .DATA_W(DATA_WIDTH)) u_row3 (
        .clk  (clk),
        .rst  (rst),
        .din  (row_in_s[2]),
        .dout (fd_data_out_3)
    );

    skew_line #(.DEPTH(4), .DATA_W(DATA_WIDTH)) u_row4 (
        .clk  (clk),
        .rst  (rst),
        .din  (row_in_s[3]),
        .dout (fd_data_out_4)
    );

    assign fd_data_out_1         = row1_out_s[DATA_WIDTH-1:0];
    assign fd_start_out          = row1_out_s[DATA_WIDTH];
    assign fd_weight_out_1       = weight_q[0];
    assign fd_weight_out_2       = weight_q[1];
    assign fd_weight_out_3       = weight_q[2];
    assign fd_weight_out_4       = weight_q[3];
    assign fd_accept_w_out_1     = accept_q[0];
    assign fd_accept_w_out_2     = accept_q[1];
    assign fd_accept_w_out_3     = accept_q[2];
    assign fd_accept_w_out_4     = accept_q[3];
    assign fd_switch_out         = switch_q;
    assign fd_col_size_out       = col_size_q;
    assign fd_col_size_valid_out = col_size_valid_q;

    assign bus.tile_ready = (state_q == IDLE);
    assign bus.w_ready    = (state_q == LOAD_W);
    assign bus.act_ready  = (state_q == STREAM);
    assign bus.tile_done  = done_q;

endmodule
